pollard_gcd: RTL and testbench
==============================

POLLARD_GCD -- requirements
Module: pollard_gcd

Interface
REQ-001 Parameter WIDTH, default 64, operand and result bit width.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  input  1  request to load operands; sampled only in IDLE.
REQ-005 residue  input  WIDTH  a^M mod n from the modular-power stage.
REQ-006 modulus  input  WIDTH  n, the number being factored.
REQ-007 busy  output  1  high from the cycle after start is accepted until done.
REQ-008 done  output  1  one-cycle pulse when results become valid.
REQ-009 gcd_out  output  WIDTH  gcd(residue-1 mod n, n).
REQ-010 factor_found  output  1  high when 1 < gcd_out < modulus.
REQ-011 invalid  output  1  high when modulus < 2.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, STRIP, REDUCE and FINISH, with encodings from the shared package.
REQ-013 IDLE with start=1 SHALL latch residue and modulus and go to LOAD; start in any other state SHALL be ignored.
REQ-014 LOAD SHALL set a = (residue==0) ? modulus-1 : residue-1 and b = modulus, clear shift count k, and go to STRIP; if modulus < 2 it SHALL go to FINISH with invalid=1 and gcd_out=0.
REQ-015 In LOAD, a==0 (residue==1) SHALL go directly to FINISH with gcd = modulus.
REQ-016 STRIP SHALL, each cycle that both a and b are even, shift both right by 1 and increment k; otherwise it SHALL go to REDUCE.
REQ-017 REDUCE SHALL do exactly one action per cycle, in priority order: a==0 -> FINISH; a even -> a>>=1; b even -> b>>=1; a>=b -> a=a-b; else b=b-a.
REQ-018 FINISH SHALL set gcd_out = b<<k, evaluate factor_found and invalid, assert done for exactly one cycle, and return to IDLE.
REQ-019 busy SHALL be high in LOAD, STRIP and REDUCE and low in IDLE and FINISH.
REQ-020 Total latency from start acceptance to done SHALL be at most 4*WIDTH+3 cycles.
REQ-021 gcd_out, factor_found and invalid SHALL hold until the next accepted start, and SHALL clear in the LOAD cycle.
REQ-022 All subtractions SHALL be unsigned WIDTH-bit with no overflow possible, since the subtrahend never exceeds the minuend; k SHALL be $clog2(WIDTH)+1 bits.

Reset
REQ-023 Reset SHALL return the FSM to IDLE and clear busy, done, gcd_out, factor_found, invalid, a, b and k to 0.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Configuration
REQ-025 With POLLARD_GCD_CYCLE_COUNT_EN defined, an output cycle_count [15:0] SHALL count busy cycles of the last operation (saturating at 16'hFFFF), clear on LOAD and hold after done.
REQ-026 Without POLLARD_GCD_CYCLE_COUNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 Package pollard_pkg SHALL hold the FSM state typedef, the WIDTH default constant and the latency bound constant.
REQ-028 The single REDUCE-step datapath SHALL be sub-module gcd_step, which is combinational: (a,b) in -> (a',b',zero) out; the FSM and registers SHALL stay in pollard_gcd.

Verification
REQ-029 residue=15, modulus=91 -> done with gcd_out=7, factor_found=1, invalid=0.
REQ-030 residue=13, modulus=48 -> gcd_out=12 (common factor 2 exercised, k=2), factor_found=1.
REQ-031 residue=1, modulus=91 -> gcd_out=91, factor_found=0; residue=3, modulus=91 -> gcd_out=1, factor_found=0.
REQ-032 modulus=1 -> done within 3 cycles with invalid=1, gcd_out=0, factor_found=0.
REQ-033 A second start while busy SHALL be ignored; reset asserted 5 cycles after start -> no done, outputs 0, next start(15,91) -> 7.
REQ-034 Random residue and odd modulus, 10k runs vs. reference gcd -> exact match, latency <= 4*WIDTH+3.

Source files
------------

// File: rtl/pollard_gcd_pkg.sv
// ----------------------------------------------------------------------------
// pollard_pkg
//   Shared definitions for the Pollard p-1 final GCD stage.
//   - state_t        : FSM state encoding used by pollard_gcd
//   - WIDTH_DEFAULT  : default operand / result width
//   - latency_bound  : worst-case cycles from start acceptance to done
//   - LATENCY_BOUND  : latency_bound evaluated at WIDTH_DEFAULT
// ----------------------------------------------------------------------------
package pollard_pkg;

    localparam int unsigned WIDTH_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STRIP  = 3'd2,
        ST_REDUCE = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    function automatic int unsigned latency_bound(input int unsigned w);
        return 4 * w + 3;
    endfunction

    localparam int unsigned LATENCY_BOUND = latency_bound(WIDTH_DEFAULT);

endpackage

// File: rtl/pollard_gcd_step.sv
// ----------------------------------------------------------------------------
// gcd_step
//   One combinational binary-GCD reduction step. Exactly one action is taken,
//   in priority order: a even -> a>>1; b even -> b>>1; a>=b -> a-b; else b-a.
//   Ports:
//     a, b     : current operands (WIDTH bits)
//     a_next   : operand a after the step
//     b_next   : operand b after the step
//     zero     : a is zero, reduction is complete and operands pass through
// ----------------------------------------------------------------------------
module gcd_step
    import pollard_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next,
    output logic             zero
);

    always_comb begin
        a_next = a;
        b_next = b;
        zero   = (a == '0);
        if (zero) begin
            a_next = a;
            b_next = b;
        end else if (!a[0]) begin
            a_next = a >> 1;
        end else if (!b[0]) begin
            b_next = b >> 1;
        end else if (a >= b) begin
            // Both odd here, so the difference is even and shrinks next step.
            a_next = a - b;
        end else begin
            b_next = b - a;
        end
    end

endmodule

// File: rtl/pollard_gcd.sv
// ----------------------------------------------------------------------------
// pollard_gcd
//   Final stage of Pollard's p-1 factoring: computes gcd(residue-1 mod n, n)
//   with a multi-cycle binary GCD (common factors of two are stripped first
//   and restored by a left shift of k at the end).
//   Ports:
//     clk          : clock, rising edge
//     reset        : asynchronous active-high reset
//     start        : load request, sampled only in IDLE
//     residue      : a^M mod n
//     modulus      : n
//     busy         : high in LOAD, STRIP and REDUCE
//     done         : one-cycle pulse when results are valid
//     gcd_out      : gcd result
//     factor_found : 1 < gcd_out < modulus
//     invalid      : modulus < 2
//     cycle_count  : busy cycles of last operation, saturating; present only
//                    when POLLARD_GCD_CYCLE_COUNT_EN is defined
// ----------------------------------------------------------------------------
module pollard_gcd
    import pollard_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] residue,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic             factor_found,
    output logic             invalid
`ifdef POLLARD_GCD_CYCLE_COUNT_EN
    ,
    output logic [15:0]      cycle_count
`endif
);

    localparam int unsigned KW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [KW-1:0]    k;

    logic [WIDTH-1:0] a_nx;
    logic [WIDTH-1:0] b_nx;
    logic             a_zero;
    logic [WIDTH-1:0] gcd_shifted;

    gcd_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .a      (a),
        .b      (b),
        .a_next (a_nx),
        .b_next (b_nx),
        .zero   (a_zero)
    );

    // b never exceeds the modulus once k is restored, so the shift cannot
    // overflow WIDTH bits.
    assign gcd_shifted = b << k;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            res_q        <= '0;
            mod_q        <= '0;
            a            <= '0;
            b            <= '0;
            k            <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            gcd_out      <= '0;
            factor_found <= 1'b0;
            invalid      <= 1'b0;
`ifdef POLLARD_GCD_CYCLE_COUNT_EN
            cycle_count  <= '0;
`endif
        end else begin
`ifdef POLLARD_GCD_CYCLE_COUNT_EN
            if (busy && (cycle_count != 16'hFFFF)) begin
                cycle_count <= cycle_count + 16'd1;
            end
`endif
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        res_q        <= residue;
                        mod_q        <= modulus;
                        // Results clear on entry so they read 0 during LOAD.
                        gcd_out      <= '0;
                        factor_found <= 1'b0;
                        invalid      <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ST_LOAD;
`ifdef POLLARD_GCD_CYCLE_COUNT_EN
                        cycle_count  <= '0;
`endif
                    end
                end

                ST_LOAD: begin
                    k <= '0;
                    b <= mod_q;
                    if (mod_q < WIDTH'(2)) begin
                        a       <= '0;
                        invalid <= 1'b1;
                        gcd_out <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_FINISH;
                    end else if (res_q == WIDTH'(1)) begin
                        // residue-1 is zero: gcd(0, n) = n, trivially no factor.
                        a            <= '0;
                        gcd_out      <= mod_q;
                        factor_found <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= ST_FINISH;
                    end else begin
                        a     <= (res_q == '0) ? (mod_q - WIDTH'(1))
                                               : (res_q - WIDTH'(1));
                        state <= ST_STRIP;
                    end
                end

                ST_STRIP: begin
                    if (!a[0] && !b[0]) begin
                        a <= a >> 1;
                        b <= b >> 1;
                        k <= k + KW'(1);
                    end else begin
                        state <= ST_REDUCE;
                    end
                end

                ST_REDUCE: begin
                    if (a_zero) begin
                        gcd_out      <= gcd_shifted;
                        factor_found <= (gcd_shifted > WIDTH'(1)) &&
                                        (gcd_shifted < mod_q);
                        invalid      <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= ST_FINISH;
                    end else begin
                        a <= a_nx;
                        b <= b_nx;
                    end
                end

                ST_FINISH: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pollard_gcd.sv
// ----------------------------------------------------------------------------
// tb_pollard_gcd
//   Directed self-checking bench for pollard_gcd (WIDTH = 64). Inputs are
//   driven and outputs sampled 1 time unit after the rising clock edge.
// ----------------------------------------------------------------------------
module tb_pollard_gcd;
    import pollard_pkg::*;

    localparam int unsigned W     = 64;
    localparam int unsigned BOUND = 4 * W + 3;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] residue;
    logic [W-1:0] modulus;
    logic         busy;
    logic         done;
    logic [W-1:0] gcd_out;
    logic         factor_found;
    logic         invalid;
`ifdef POLLARD_GCD_CYCLE_COUNT_EN
    logic [15:0]  cycle_count;
`endif

    int checks = 0;
    int errors = 0;

    pollard_gcd #(
        .WIDTH(W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .residue      (residue),
        .modulus      (modulus),
        .busy         (busy),
        .done         (done),
        .gcd_out      (gcd_out),
        .factor_found (factor_found),
        .invalid      (invalid)
`ifdef POLLARD_GCD_CYCLE_COUNT_EN
        ,
        .cycle_count  (cycle_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Euclid's algorithm as an independent reference.
    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] p, q, t;
        p = x;
        q = y;
        while (q != '0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Wait for done, counting edges after the accepting edge.
    task automatic wait_done(input string tag, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < int'(BOUND) + 20 && !seen; i++) begin
            tick();
            lat++;
            if (done) seen = 1'b1;
        end
        check({tag, " done_seen"}, W'(seen), W'(1));
        check({tag, " latency_bound"}, W'(lat <= int'(BOUND)), W'(1));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] r, input logic [W-1:0] m,
                          input logic [W-1:0] g_exp, input logic ff_exp, input logic inv_exp,
                          input int lat_exp);
        int lat;
        residue = r;
        modulus = m;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check({tag, " load_busy"}, W'(busy), W'(1));
        check({tag, " load_gcd_clear"}, gcd_out, '0);
        check({tag, " load_ff_clear"}, W'(factor_found), W'(0));
        wait_done(tag, lat);
        if (lat_exp >= 0) check({tag, " latency"}, W'(lat), W'(lat_exp));
        check({tag, " gcd"}, gcd_out, g_exp);
        check({tag, " factor"}, W'(factor_found), W'(ff_exp));
        check({tag, " invalid"}, W'(invalid), W'(inv_exp));
        check({tag, " busy_low"}, W'(busy), W'(0));
        tick();
        check({tag, " done_pulse"}, W'(done), W'(0));
        check({tag, " gcd_hold"}, gcd_out, g_exp);
    endtask

    initial begin
        logic [W-1:0] m, r, f, r1, g;
        int lat;

        reset   = 1'b1;
        start   = 1'b0;
        residue = '0;
        modulus = '0;
        tick();
        tick();
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset gcd", gcd_out, '0);
        check("reset factor", W'(factor_found), W'(0));
        check("reset invalid", W'(invalid), W'(0));
        reset = 1'b0;
        tick();

        run_op("r15_m91", 64'd15, 64'd91, 64'd7, 1'b1, 1'b0, 10);
        run_op("r13_m48", 64'd13, 64'd48, 64'd12, 1'b1, 1'b0, 8);
        run_op("r1_m91", 64'd1, 64'd91, 64'd91, 1'b0, 1'b0, 1);
        run_op("r3_m91", 64'd3, 64'd91, 64'd1, 1'b0, 1'b0, -1);
        run_op("m1_invalid", 64'd5, 64'd1, 64'd0, 1'b0, 1'b1, 1);
        run_op("r0_m9", 64'd0, 64'd9, 64'd1, 1'b0, 1'b0, -1);
        run_op("r7_m9", 64'd7, 64'd9, 64'd3, 1'b1, 1'b0, -1);

        // Hold after done across idle cycles.
        tick();
        tick();
        check("idle hold gcd", gcd_out, 64'd3);
        check("idle hold factor", W'(factor_found), W'(1));

        // Second start while busy is ignored.
        residue = 64'd15;
        modulus = 64'd91;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        tick();
        check("ignore busy_high", W'(busy), W'(1));
        residue = 64'd2;
        modulus = 64'd4;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_done("ignore", lat);
        check("ignore gcd", gcd_out, 64'd7);
        check("ignore factor", W'(factor_found), W'(1));
        tick();

        // Reset mid-operation aborts with no done pulse.
        residue = 64'd15;
        modulus = 64'd91;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("abort busy_before", W'(busy), W'(1));
        reset = 1'b1;
        #1;
        check("abort busy", W'(busy), W'(0));
        check("abort done", W'(done), W'(0));
        check("abort gcd", gcd_out, '0);
        check("abort factor", W'(factor_found), W'(0));
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort no_done", W'(done), W'(0));
        end
        run_op("after_reset", 64'd15, 64'd91, 64'd7, 1'b1, 1'b0, 10);

        // Randomised runs against the Euclid reference.
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                m = {$urandom, $urandom} | 64'd1;
                if (m < 64'd3) m = 64'd3;
                r = {$urandom, $urandom} % m;
            end else begin
                f = {32'd0, $urandom} | 64'd1;
                m = f * ({32'd0, $urandom} | 64'd1);
                if (m < 64'd3) m = 64'd3;
                r = ((f * {32'd0, $urandom}) % m) + 64'd1;
            end
            r1 = (r == '0) ? (m - 64'd1) : (r - 64'd1);
            g  = (r1 == '0) ? m : ref_gcd(r1, m);
            run_op("random", r, m, g, (g > 64'd1) && (g < m), 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
